// File: rtl/conv_row_loader.sv
// Row producer: fetches feature-map rows from buffer RAM, commits them into the kernel
// shift-register bank and paces the convolution controller. Zero padding: CONV_ROW_LOADER_ZERO_PAD_EN.
module conv_row_loader #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int ROW_LEN     = 4,
    parameter int NUM_SR_ROWS = 4,
    parameter int IMG_ROWS    = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  load_wr_en,
    output logic [15:0]           load_wr_col,
    output logic [DATA_WIDTH-1:0] load_wr_data,
    output logic                  row_commit,
    input  logic                  shift_row_up,
    output logic                  row_shift_in_rdy,
    output logic                  input_start,
    output logic                  busy,
    output logic                  frame_done
);

`ifdef CONV_ROW_LOADER_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int          TOTAL_ROWS = IMG_ROWS + (PAD_EN ? 2 : 0);
    localparam logic [15:0] TOTAL16    = 16'(TOTAL_ROWS);
    localparam logic [15:0] NSR16      = 16'(NUM_SR_ROWS);
    localparam logic [15:0] LAST_COL   = 16'(ROW_LEN - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [15:0]           rows_fetched_q;
    logic [15:0]           rows_committed_q;
    logic                  iss_vld_q;
    logic                  iss_pad_q;
    logic [15:0]           iss_col_q;
    logic                  mem_rd_en_q;
    logic                  load_wr_en_q;
    logic                  wr_pad_q;
    logic [15:0]           load_wr_col_q;
    logic                  row_full_q;
    logic                  input_start_q;
    logic                  frame_done_q;

    logic                  rdy;
    logic                  accept;
    logic                  commit;
    logic                  fetch_go;
    logic                  fetch_pad;
    logic [15:0]           fetch_row;
    logic [15:0]           img_row;
    logic [ADDR_WIDTH-1:0] base_src;
    logic [ADDR_WIDTH-1:0] fetch_base;

    always_comb begin
        rdy = 1'b0;
        case (state_q)
            RUN:     rdy = !shift_row_up || row_full_q;
            DRAIN:   rdy = 1'b1;
            default: rdy = 1'b0;
        endcase
        accept = shift_row_up && rdy;
        commit = (state_q == FILL && row_full_q) || (state_q == RUN && accept);

        // A new row is fetched on the frame start and on every commit while rows remain.
        fetch_row  = (state_q == IDLE) ? 16'd0 : rows_fetched_q;
        fetch_go   = (state_q == IDLE && start) || (commit && rows_fetched_q < TOTAL16);
        fetch_pad  = PAD_EN && (fetch_row == 16'd0 || fetch_row == TOTAL16 - 16'd1);
        img_row    = fetch_row - (PAD_EN ? 16'd1 : 16'd0);
        base_src   = (state_q == IDLE) ? base_addr : base_q;
        fetch_base = base_src + ADDR_WIDTH'(32'(img_row) * ROW_LEN);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            base_q           <= '0;
            mem_addr_q       <= '0;
            rows_fetched_q   <= '0;
            rows_committed_q <= '0;
            iss_vld_q        <= 1'b0;
            iss_pad_q        <= 1'b0;
            iss_col_q        <= '0;
            mem_rd_en_q      <= 1'b0;
            load_wr_en_q     <= 1'b0;
            wr_pad_q         <= 1'b0;
            load_wr_col_q    <= '0;
            row_full_q       <= 1'b0;
            input_start_q    <= 1'b0;
            frame_done_q     <= 1'b0;
        end else begin
            input_start_q <= 1'b0;
            frame_done_q  <= 1'b0;

            if (fetch_go) begin
                iss_vld_q      <= 1'b1;
                iss_pad_q      <= fetch_pad;
                iss_col_q      <= '0;
                mem_rd_en_q    <= !fetch_pad;
                mem_addr_q     <= fetch_base;
                rows_fetched_q <= fetch_row + 16'd1;
            end else if (iss_vld_q && iss_col_q != LAST_COL) begin
                iss_col_q <= iss_col_q + 16'd1;
                if (mem_rd_en_q) mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
            end else begin
                iss_vld_q   <= 1'b0;
                iss_pad_q   <= 1'b0;
                iss_col_q   <= '0;
                mem_rd_en_q <= 1'b0;
            end

            // Read data arrives one cycle after the strobe; writes trail the issue stage by one.
            load_wr_en_q  <= iss_vld_q;
            load_wr_col_q <= iss_col_q;
            wr_pad_q      <= iss_pad_q;

            if (commit)
                row_full_q <= 1'b0;
            else if (load_wr_en_q && load_wr_col_q == LAST_COL)
                row_full_q <= 1'b1;

            if (commit) rows_committed_q <= rows_committed_q + 16'd1;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q           <= base_addr;
                        rows_committed_q <= '0;
                        state_q          <= FILL;
                    end
                end
                FILL: begin
                    if (commit && rows_committed_q == NSR16 - 16'd1) begin
                        state_q       <= (TOTAL16 == NSR16) ? DRAIN : RUN;
                        input_start_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (commit && rows_committed_q == TOTAL16 - 16'd1) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (accept) begin
                        frame_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_rd_en        = mem_rd_en_q;
    assign mem_addr         = mem_addr_q;
    assign load_wr_en       = load_wr_en_q;
    assign load_wr_col      = load_wr_col_q;
    assign load_wr_data     = (load_wr_en_q && !wr_pad_q) ? mem_rd_data : '0;
    assign row_commit       = commit;
    assign row_shift_in_rdy = rdy;
    assign input_start      = input_start_q;
    assign busy             = (state_q != IDLE);
    assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_conv_row_loader.sv
// Directed bench for conv_row_loader: fill timing, stall, full frame, ignored start, reset abort.
module tb_conv_row_loader;

    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int MAXC = 80;
`ifdef CONV_ROW_LOADER_ZERO_PAD_EN
    localparam int PADI = 1;
`else
    localparam int PADI = 0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          load_wr_en;
    logic [15:0]   load_wr_col;
    logic [DW-1:0] load_wr_data;
    logic          row_commit;
    logic          shift_row_up = 1'b0;
    logic          row_shift_in_rdy;
    logic          input_start;
    logic          busy;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic        rec_rd   [0:MAXC];
    logic [15:0] rec_addr [0:MAXC];
    logic        rec_wr   [0:MAXC];
    logic [15:0] rec_col  [0:MAXC];
    logic [7:0]  rec_data [0:MAXC];
    logic        rec_cm   [0:MAXC];
    logic        rec_rdy  [0:MAXC];
    logic        rec_is   [0:MAXC];
    logic        rec_busy [0:MAXC];
    logic        rec_fd   [0:MAXC];
    logic        rec_acc  [0:MAXC];

    conv_row_loader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROW_LEN(4), .NUM_SR_ROWS(4), .IMG_ROWS(6)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .load_wr_en(load_wr_en), .load_wr_col(load_wr_col), .load_wr_data(load_wr_data),
        .row_commit(row_commit), .shift_row_up(shift_row_up),
        .row_shift_in_rdy(row_shift_in_rdy), .input_start(input_start),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    // Buffer RAM model: each location holds its own address low byte.
    always @(posedge clock) if (mem_rd_en) mem_rd_data <= mem_addr[7:0];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: shift_row_up low; 1: held from 28 until a commit; 2: pulsed every 4 cycles from 25
    // plus stray starts; 3: reset asserted at 15 and released at 18.
    task automatic run(input int ncyc, input int mode);
        bit seen;
        seen = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            if (mode == 2 && (c == 10 || c == 26)) begin
                start     = 1'b1;
                base_addr = 16'h0500;
            end
            if (mode == 3 && c == 15) reset = 1'b0;
            if (mode == 3 && c == 18) reset = 1'b1;
            case (mode)
                1:       shift_row_up = (c >= 28) && !seen;
                2:       shift_row_up = (c >= 25) && ((c - 25) % 4 == 0);
                default: shift_row_up = 1'b0;
            endcase
            #1;
            rec_rd[c]   = mem_rd_en;
            rec_addr[c] = mem_addr;
            rec_wr[c]   = load_wr_en;
            rec_col[c]  = load_wr_col;
            rec_data[c] = load_wr_data;
            rec_cm[c]   = row_commit;
            rec_rdy[c]  = row_shift_in_rdy;
            rec_is[c]   = input_start;
            rec_busy[c] = busy;
            rec_fd[c]   = frame_done;
            rec_acc[c]  = shift_row_up && row_shift_in_rdy;
            if (mode == 1 && c >= 28 && row_commit) seen = 1'b1;
        end
        start        = 1'b0;
        shift_row_up = 1'b0;
    endtask

    task automatic begin_frame(input logic [AW-1:0] addr);
        start     = 1'b1;
        base_addr = addr;
    endtask

    // Fill phase with shift_row_up low: row k reads at 1+6k..4+6k, writes one cycle later.
    task automatic check_fill(input string nm, input int base);
        int  k, j, kw, jw, ea, ed;
        bit  exp_rd, exp_wr;
        for (int c = 1; c <= 30; c++) begin
            k      = (c - 1) / 6;
            j      = (c - 1) % 6;
            exp_rd = (j < 4) && (c <= 28) && !(PADI == 1 && k == 0);
            check_val($sformatf("%s rd_en@%0d", nm, c), rec_rd[c], exp_rd);
            if (exp_rd) begin
                ea = (base + 4 * (k - PADI) + j) & 16'hFFFF;
                check_val($sformatf("%s addr@%0d", nm, c), rec_addr[c], ea);
            end
            kw     = (c - 2) / 6;
            jw     = (c - 2) % 6;
            exp_wr = (c >= 2) && (jw < 4) && (c <= 29);
            check_val($sformatf("%s wr_en@%0d", nm, c), rec_wr[c], exp_wr);
            if (exp_wr) begin
                ed = (PADI == 1 && kw == 0) ? 0 : ((base + 4 * (kw - PADI) + jw) & 8'hFF);
                check_val($sformatf("%s wr_col@%0d", nm, c), rec_col[c], jw);
                check_val($sformatf("%s wr_data@%0d", nm, c), rec_data[c], ed);
            end
            check_val($sformatf("%s commit@%0d", nm, c), rec_cm[c], (c % 6 == 0) && (c <= 24));
            check_val($sformatf("%s in_start@%0d", nm, c), rec_is[c], c == 25);
            check_val($sformatf("%s rdy@%0d", nm, c), rec_rdy[c], c >= 25);
            check_val($sformatf("%s busy@%0d", nm, c), rec_busy[c], 1);
        end
    endtask

    initial begin
        int n_acc, n_cm, n_fd, fd_c;

        // Reset state
        repeat (3) @(posedge clock);
        #2;
        check_val("rst mem_rd_en", mem_rd_en, 0);
        check_val("rst load_wr_en", load_wr_en, 0);
        check_val("rst row_commit", row_commit, 0);
        check_val("rst rdy", row_shift_in_rdy, 0);
        check_val("rst input_start", input_start, 0);
        check_val("rst busy", busy, 0);
        check_val("rst frame_done", frame_done, 0);
        reset = 1'b1;
        @(posedge clock);
        #2;

        // Basic fill
        begin_frame(16'h0100);
        run(30, 0);
        check_fill("fill", 16'h0100);

        // Stall: rdy low 28-29, commit at 30, next row fetched from 31
        reset = 1'b0;
        #2;
        reset = 1'b1;
        begin_frame(16'h0100);
        run(36, 1);
        for (int c = 25; c <= 29; c++)
            check_val($sformatf("stall no_commit@%0d", c), rec_cm[c], 0);
        check_val("stall rdy@28", rec_rdy[28], 0);
        check_val("stall rdy@29", rec_rdy[29], 0);
        check_val("stall rdy@30", rec_rdy[30], 1);
        check_val("stall commit@30", rec_cm[30], 1);
        check_val("stall rdy@31", rec_rdy[31], 1);
        check_val("stall rd@31", rec_rd[31], 1);
        check_val("stall addr@31", rec_addr[31], 16'h0114 - 16'(4 * PADI));

        // Full frame with stray starts at 10 and 26
        reset = 1'b0;
        #2;
        reset = 1'b1;
        begin_frame(16'h0100);
        run(70, 2);
        n_acc = 0; n_cm = 0; n_fd = 0; fd_c = -1;
        for (int c = 1; c <= 70; c++) begin
            if (rec_acc[c]) n_acc++;
            if (rec_cm[c]) n_cm++;
            if (rec_fd[c]) begin
                n_fd++;
                if (fd_c < 0) fd_c = c;
            end
        end
        check_val("frame accepted_shifts", n_acc, 3 + 2 * PADI);
        check_val("frame commits", n_cm, 6 + 2 * PADI);
        check_val("frame done_pulses", n_fd, 1);
        check_val("frame done_cycle", fd_c, 46 + 16 * PADI);
        check_val("frame commit@33", rec_cm[33], 1);
        check_val("frame commit@41", rec_cm[41], 1);
        check_val("frame addr@7", rec_addr[7], 16'h0104 - 16'(4 * PADI));
        check_val("frame addr@25", rec_addr[25], 16'h0110 - 16'(4 * PADI));
        check_val("frame addr@34", rec_addr[34], 16'h0114 - 16'(4 * PADI));
        check_val("frame busy_before_done", rec_busy[45 + 16 * PADI], 1);
        check_val("frame busy_at_done", rec_busy[46 + 16 * PADI], 0);
        check_val("frame rdy_at_done", rec_rdy[46 + 16 * PADI], 0);

        // New frame after frame_done
        begin_frame(16'h0200);
        run(8, 0);
        check_val("refr busy@1", rec_busy[1], 1);
        check_val("refr rd@1", rec_rd[1], 1 - PADI);
        check_val("refr commit@6", rec_cm[6], 1);
        check_val("refr rd@7", rec_rd[7], 1);
        check_val("refr addr@7", rec_addr[7], 16'h0204 - 16'(4 * PADI));

        // Reset mid-frame at cycle 15
        reset = 1'b0;
        #2;
        reset = 1'b1;
        begin_frame(16'h0100);
        run(30, 3);
        check_val("rstm rd@14", rec_rd[14], 1);
        check_val("rstm rd@15", rec_rd[15], 0);
        check_val("rstm addr@15", rec_addr[15], 0);
        check_val("rstm wr@15", rec_wr[15], 0);
        check_val("rstm col@15", rec_col[15], 0);
        check_val("rstm data@15", rec_data[15], 0);
        check_val("rstm commit@15", rec_cm[15], 0);
        check_val("rstm rdy@15", rec_rdy[15], 0);
        check_val("rstm in_start@15", rec_is[15], 0);
        check_val("rstm busy@15", rec_busy[15], 0);
        for (int c = 16; c <= 30; c++) begin
            check_val($sformatf("rstm busy@%0d", c), rec_busy[c], 0);
            check_val($sformatf("rstm fdone@%0d", c), rec_fd[c], 0);
            check_val($sformatf("rstm rd@%0d", c), rec_rd[c], 0);
        end
        begin_frame(16'h0100);
        run(30, 0);
        check_fill("refill", 16'h0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_row_loader.md
# conv_row_loader

Row producer for the convolution datapath. It fetches a feature map from a single-port buffer RAM one row at a time, assembles each row in a load row, and commits rows into the kernel shift-register bank. It drives the convolution controller's `row_shift_in_rdy`/`input_start` handshake and advances one row on every accepted `shift_row_up`.

## Interface
- `DATA_WIDTH`, 8: element width.
- `ADDR_WIDTH`, 16: buffer RAM address width.
- `ROW_LEN`, 4: elements per row; equals the shift-register depth.
- `NUM_SR_ROWS`, 4: rows held in the shift-register bank.
- `IMG_ROWS`, 6: rows per image; must be ≥ `NUM_SR_ROWS`.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  one-cycle frame request; also latches `base_addr`.
- `base_addr`  in  ADDR_WIDTH  address of element (0,0); row-major, contiguous.
- `mem_rd_en`  out  1  RAM read strobe.
- `mem_addr`  out  ADDR_WIDTH  RAM read address.
- `mem_rd_data`  in  DATA_WIDTH  RAM data, valid 1 cycle after `mem_rd_en`.
- `load_wr_en`  out  1  write one element into the load row.
- `load_wr_col`  out  16  column index of the write.
- `load_wr_data`  out  DATA_WIDTH  element value.
- `row_commit`  out  1  shift load row into bank bottom, bank shifts up one.
- `shift_row_up`  in  1  from the convolution controller: band finished.
- `row_shift_in_rdy`  out  1  to the controller: enable.
- `input_start`  out  1  to the controller: counter restart, one cycle.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse after the final band is accepted.

## Operation
- States: IDLE, FILL, RUN, DRAIN. Reset → IDLE; every output is 0 and all counters are 0.
- IDLE: `start` latches `base_addr`, clears `rows_fetched` and `rows_committed` (16-bit), and enters FILL. `start` is ignored outside IDLE.
- Fetch engine: issues `ROW_LEN` reads on consecutive cycles.
  - Address = base + row·ROW_LEN + col, truncated to `ADDR_WIDTH` (wraps).
  - Each read returns one cycle later as a `load_wr_en` write at the same column.
  - `row_full` sets on the last write and clears on `row_commit`.
  - The next fetch never starts before the commit of the previous row.
- FILL: fetch row, then `row_commit` in the cycle after `row_full` sets; repeat until `NUM_SR_ROWS` rows are committed.
  - After the final fill commit: go to RUN, or to DRAIN if `IMG_ROWS == NUM_SR_ROWS`.
  - `input_start` pulses in the first RUN/DRAIN cycle.
  - The next fetch begins in that same cycle if rows remain.
- RUN: `row_shift_in_rdy = !shift_row_up || row_full`. This is a combinational path from `shift_row_up`.
  - Accepted shift = `shift_row_up && row_shift_in_rdy`. It asserts `row_commit` in that cycle.
  - The fetch of the next row starts the following cycle, if any row remains.
  - Once the last image row is committed, go to DRAIN.
- DRAIN: `row_shift_in_rdy = 1`. The next accepted shift pulses `frame_done` and returns to IDLE.
- Bands per frame = `IMG_ROWS − NUM_SR_ROWS + 1`.
- `busy` = state ≠ IDLE.

## Timing
- `start` sampled at cycle 0. Reads at cycles 1–4 (`ROW_LEN`=4), writes at 2–5, `row_commit` at 6, next reads from 7.
- Fill commits at cycles 6, 12, 18, 24. `row_shift_in_rdy` rises and `input_start` pulses at 25.
- Prefetch of row 4: reads 25–28, writes 26–29, `row_full` from 30.
- Stall: `shift_row_up` high from cycle 28 holds `rdy` low until 30. Commit occurs at 30.
- `shift_row_up` while `row_full` is already set: commit in the same cycle, no stall.
- Reset mid-frame: immediate return to IDLE, outputs 0, fetch aborted, no `frame_done`.

## Configuration
- `CONV_ROW_LOADER_ZERO_PAD_EN` defined:
  - One zero row is inserted above and below the image, so effective rows = `IMG_ROWS + 2`.
  - Pad rows produce `ROW_LEN` writes of 0 with no `mem_rd_en`, using the same cycle timing as a fetched row.
  - Row addresses are computed from the unpadded row index.
  - Bands = `IMG_ROWS + 3 − NUM_SR_ROWS`.
- Undefined: no padding, behaviour exactly as above.

## Test plan
- Basic fill (defaults), base=0x100, data = address low byte, `shift_row_up` tied 0 → reads 0x100–0x10F; commits at cycles 6/12/18/24; `input_start` at 25 only; prefetch reads 0x110–0x113.
- Full frame (`IMG_ROWS`=6), `shift_row_up` pulsed every 4 cycles once `rdy` is high → exactly 3 accepted shifts; commits of rows 4 and 5; `frame_done` on the 3rd shift; back to IDLE.
- Stall: `shift_row_up` held from cycle 28 → `rdy` low at cycles 28–29; commit and `rdy` at cycle 30; no commit before 30.
- `start` pulsed at cycle 10 and 26 of a frame → ignored; addresses unchanged; a `start` after `frame_done` begins a new frame.
- Reset asserted at cycle 15 → all outputs 0 within the cycle; no `frame_done`; a later `start` refills from scratch.
- `ZERO_PAD_EN` defined, `IMG_ROWS`=6 → first commit carries zeros with no reads; 8 total commits; 5 bands; first RAM read at address base+0 for row 1.
